// File: rtl/motor_cmd_ramp.sv
// Two-channel slew limiter feeding the motor pulse generator: ramps MC1/MC2 toward latched
// targets once per tick, dwells at neutral on reversal. Optional watchdog: MC_CMD_WATCHDOG_EN.
`timescale 1ns/1ps
module motor_cmd_ramp #(
  parameter int unsigned STEP_CYCLES = 1200000,
  parameter int unsigned STEP_SIZE   = 1,
  parameter int unsigned STOP_CODE   = 16,
  parameter int unsigned DWELL_STEPS = 4,
  parameter int unsigned WDOG_STEPS  = 50
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [4:0] CMD_LEFT,
  input  logic [4:0] CMD_RIGHT,
  input  logic       ESTOP,
  output logic [4:0] MC1,
  output logic [4:0] MC2,
  output logic       AT_TARGET,
  output logic       WDOG_TRIP,
  output logic       TICK
);

  localparam int unsigned TCW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int unsigned DCW = (DWELL_STEPS > 0) ? $clog2(DWELL_STEPS + 1) : 1;

  localparam logic [TCW-1:0] TickLast  = TCW'(STEP_CYCLES - 1);
  localparam logic [4:0]     Stop      = 5'(STOP_CODE);
  localparam logic [5:0]     Step      = 6'(STEP_SIZE);
  localparam logic [DCW-1:0] DwellInit = DCW'(DWELL_STEPS);

  localparam logic [1:0] StRun  = 2'd0;
  localparam logic [1:0] StWdog = 2'd1;
  localparam logic [1:0] StHalt = 2'd2;

  if (STEP_CYCLES < 2 || STEP_SIZE < 1 || STEP_SIZE > 31 || STOP_CODE > 31 ||
      WDOG_STEPS < 1) begin : g_param_check
    $error("motor_cmd_ramp: parameter out of range");
  end

  logic [TCW-1:0]          r_tick_cnt;
  logic                    r_tick;
  logic [1:0]              r_state;
  logic                    r_ready;
  logic [1:0][4:0]         r_cur;
  logic [1:0][4:0]         r_tgt;
  logic [1:0][DCW-1:0]     r_dwell;
  logic [1:0]              r_dir;

  logic                    w_wrap;
  logic                    w_accept;
  logic                    w_ramp;
  logic                    w_fire;
  logic [1:0]              w_state_d;
  logic [1:0][4:0]         w_tgt_d;
  logic [1:0][4:0]         w_cur_d;
  logic [1:0][DCW-1:0]     w_dwell_d;
  logic [1:0]              w_dir_d;
  logic [1:0]              w_rev;
  logic [1:0]              w_keep;
  logic [1:0][4:0]         w_eff;
  logic [1:0][4:0]         w_stepped;

  // Move cur toward eff by at most Step; 6-bit math so nothing wraps past 0 or 31.
  function automatic logic [4:0] f_step(input logic [4:0] cur, input logic [4:0] eff);
    logic [5:0] c6;
    logic [5:0] e6;
    logic [5:0] s6;
    c6 = {1'b0, cur};
    e6 = {1'b0, eff};
    s6 = c6;
    if (c6 < e6) begin
      s6 = ((c6 + Step) >= e6) ? e6 : (c6 + Step);
    end else if (c6 > e6) begin
      s6 = (c6 < (e6 + Step)) ? e6 : (c6 - Step);
    end
    return s6[4:0];
  endfunction

  assign w_wrap   = (r_tick_cnt == TickLast);
  assign w_accept = CMD_VALID && r_ready && !ESTOP;
  assign w_ramp   = w_wrap && ((r_state == StRun) || (r_state == StWdog));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tick_cnt <= '0;
      r_tick     <= 1'b0;
    end else begin
      r_tick_cnt <= w_wrap ? '0 : r_tick_cnt + TCW'(1);
      r_tick     <= w_wrap;
    end
  end

`ifdef MC_CMD_WATCHDOG_EN
  localparam int unsigned WCW = $clog2(WDOG_STEPS + 1);
  localparam logic [WCW-1:0] WdogMax = WCW'(WDOG_STEPS);

  logic [WCW-1:0] r_wdog_cnt;
  logic [WCW-1:0] w_wdog_inc;
  logic           r_wdog_trip;

  assign w_wdog_inc = (r_wdog_cnt == WdogMax) ? r_wdog_cnt : r_wdog_cnt + WCW'(1);
  // An accept on the firing tick wins, so the watchdog never fires that edge.
  assign w_fire = (r_state == StRun) && w_wrap && !w_accept && !ESTOP &&
                  (w_wdog_inc == WdogMax);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wdog_cnt  <= '0;
      r_wdog_trip <= 1'b0;
    end else begin
      if (ESTOP || (r_state == StHalt) || w_accept) begin
        r_wdog_cnt <= '0;
      end else if ((r_state == StRun) && w_wrap) begin
        r_wdog_cnt <= w_wdog_inc;
      end
      if (w_accept) begin
        r_wdog_trip <= 1'b0;
      end else if (w_fire) begin
        r_wdog_trip <= 1'b1;
      end
    end
  end

  assign WDOG_TRIP = r_wdog_trip;
`else
  assign w_fire    = 1'b0;
  assign WDOG_TRIP = 1'b0;
`endif

  always_comb begin
    w_state_d = r_state;
    w_tgt_d   = r_tgt;
    if (ESTOP) begin
      w_state_d = StHalt;
      w_tgt_d   = {Stop, Stop};
    end else if (r_state == StHalt) begin
      w_state_d = StRun;
    end else if (w_accept) begin
      w_state_d = StRun;
      w_tgt_d   = {CMD_RIGHT, CMD_LEFT};
    end else if (w_fire) begin
      w_state_d = StWdog;
      w_tgt_d   = {Stop, Stop};
    end
  end

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      w_rev[c] = ((r_cur[c] > Stop) && (w_tgt_d[c] < Stop)) ||
                 ((r_cur[c] < Stop) && (w_tgt_d[c] > Stop));
      w_eff[c]     = w_rev[c] ? Stop : w_tgt_d[c];
      w_stepped[c] = f_step(r_cur[c], w_eff[c]);
      // Dwell survives a retarget only if the new target keeps the pending direction.
      w_keep[c]    = r_dir[c] ? (w_tgt_d[c] > Stop) : (w_tgt_d[c] < Stop);
    end
  end

  always_comb begin
    w_cur_d   = r_cur;
    w_dwell_d = r_dwell;
    w_dir_d   = r_dir;
    for (int c = 0; c < 2; c++) begin
      if (ESTOP) begin
        w_cur_d[c]   = Stop;
        w_dwell_d[c] = '0;
      end else if ((r_dwell[c] != '0) && !w_keep[c]) begin
        w_dwell_d[c] = '0;
      end else if (w_ramp) begin
        if (r_dwell[c] != '0) begin
          w_dwell_d[c] = r_dwell[c] - DCW'(1);
        end else begin
          w_cur_d[c] = w_stepped[c];
          if (w_rev[c] && (w_stepped[c] == Stop)) begin
            w_dwell_d[c] = DwellInit;
            w_dir_d[c]   = (w_tgt_d[c] > Stop);
          end
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= StRun;
      r_ready <= 1'b0;
      r_cur   <= {Stop, Stop};
      r_tgt   <= {Stop, Stop};
      r_dwell <= '0;
      r_dir   <= '0;
    end else begin
      r_state <= w_state_d;
      r_ready <= (w_state_d != StHalt);
      r_cur   <= w_cur_d;
      r_tgt   <= w_tgt_d;
      r_dwell <= w_dwell_d;
      r_dir   <= w_dir_d;
    end
  end

  assign CMD_READY = r_ready;
  assign MC1       = r_cur[0];
  assign MC2       = r_cur[1];
  assign TICK      = r_tick;
  assign AT_TARGET = (r_cur == r_tgt) && (r_dwell[0] == '0) && (r_dwell[1] == '0);

endmodule

// File: tb/tb_motor_cmd_ramp.sv
// Scoreboard bench for motor_cmd_ramp: three instances (step 1, step 5, watchdog-sized);
// expected per-tick outputs are queued by the stimulus and checked by per-instance monitors.
`timescale 1ns/1ps
module tb_motor_cmd_ramp;

  typedef struct packed {
    logic [4:0] mc1;
    logic [4:0] mc2;
    logic       at;
    logic       wd;
  } exp_t;

  logic       CLK;
  logic       RST;
  logic       ESTOP;
  logic       valid [3];
  logic [4:0] cl    [3];
  logic [4:0] cr    [3];
  logic       ready [3];
  logic [4:0] mc1   [3];
  logic [4:0] mc2   [3];
  logic       at    [3];
  logic       wd    [3];
  logic       tick  [3];

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int n_tests = 0;
  int n_fail  = 0;

  motor_cmd_ramp #(.STEP_CYCLES(4), .STEP_SIZE(1), .STOP_CODE(16), .DWELL_STEPS(2),
                   .WDOG_STEPS(40)) u_a (
    .CLK(CLK), .RST(RST), .CMD_VALID(valid[0]), .CMD_READY(ready[0]), .CMD_LEFT(cl[0]),
    .CMD_RIGHT(cr[0]), .ESTOP(ESTOP), .MC1(mc1[0]), .MC2(mc2[0]), .AT_TARGET(at[0]),
    .WDOG_TRIP(wd[0]), .TICK(tick[0]));

  motor_cmd_ramp #(.STEP_CYCLES(4), .STEP_SIZE(5), .STOP_CODE(16), .DWELL_STEPS(2),
                   .WDOG_STEPS(40)) u_b (
    .CLK(CLK), .RST(RST), .CMD_VALID(valid[1]), .CMD_READY(ready[1]), .CMD_LEFT(cl[1]),
    .CMD_RIGHT(cr[1]), .ESTOP(1'b0), .MC1(mc1[1]), .MC2(mc2[1]), .AT_TARGET(at[1]),
    .WDOG_TRIP(wd[1]), .TICK(tick[1]));

  motor_cmd_ramp #(.STEP_CYCLES(4), .STEP_SIZE(1), .STOP_CODE(16), .DWELL_STEPS(2),
                   .WDOG_STEPS(8)) u_w (
    .CLK(CLK), .RST(RST), .CMD_VALID(valid[2]), .CMD_READY(ready[2]), .CMD_LEFT(cl[2]),
    .CMD_RIGHT(cr[2]), .ESTOP(1'b0), .MC1(mc1[2]), .MC2(mc2[2]), .AT_TARGET(at[2]),
    .WDOG_TRIP(wd[2]), .TICK(tick[2]));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_tick(input string nm, input int d, input exp_t e);
    chk({nm, ".mc1"}, int'(mc1[d]), int'(e.mc1));
    chk({nm, ".mc2"}, int'(mc2[d]), int'(e.mc2));
    chk({nm, ".at_target"}, int'(at[d]), int'(e.at));
    chk({nm, ".wdog_trip"}, int'(wd[d]), int'(e.wd));
  endtask

  // Monitors: one queued expectation per TICK strobe, sampled mid-cycle.
  always @(negedge CLK) if (!RST && tick[0] && q0.size() != 0) chk_tick("a_tick", 0, q0.pop_front());
  always @(negedge CLK) if (!RST && tick[1] && q1.size() != 0) chk_tick("b_tick", 1, q1.pop_front());
  always @(negedge CLK) if (!RST && tick[2] && q2.size() != 0) chk_tick("w_tick", 2, q2.pop_front());

  function automatic int qsize(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic push(input int d, input int m1, input int m2, input int a, input int w);
    exp_t e;
    e.mc1 = 5'(m1);
    e.mc2 = 5'(m2);
    e.at  = a[0];
    e.wd  = w[0];
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Leaves time at negedge+1 of the cycle that shows the last expected TICK.
  task automatic drain(input int d);
    int n = 0;
    do begin
      @(negedge CLK);
      #1;
      n++;
    end while (qsize(d) != 0 && n < 300);
    if (qsize(d) != 0) begin
      chk("drain_timeout", qsize(d), 0);
      case (d)
        0:       q0.delete();
        1:       q1.delete();
        default: q2.delete();
      endcase
    end
  endtask

  task automatic wait_tick(input int d);
    int n = 0;
    do begin
      @(negedge CLK);
      #1;
      n++;
    end while (!tick[d] && n < 50);
    if (!tick[d]) chk("tick_timeout", 0, 1);
  endtask

  // dly negedges after a TICK cycle: 1 lands mid-frame, 3 lands on the wrap edge.
  task automatic cmd(input int d, input int dly, input int l, input int r);
    repeat (dly) @(negedge CLK);
    valid[d] = 1'b1;
    cl[d]    = 5'(l);
    cr[d]    = 5'(r);
    chk("cmd_ready", int'(ready[d]), 1);
    @(posedge CLK);
    #1;
    valid[d] = 1'b0;
  endtask

  task automatic estop_pulse(input int hold);
    ESTOP = 1'b1;
    @(posedge CLK);
    #1;
    chk("estop_mc1", int'(mc1[0]), 16);
    chk("estop_mc2", int'(mc2[0]), 16);
    chk("estop_ready", int'(ready[0]), 0);
    repeat (hold) @(posedge CLK);
    #1;
    chk("estop_hold_mc1", int'(mc1[0]), 16);
    chk("estop_hold_ready", int'(ready[0]), 0);
    @(negedge CLK);
    ESTOP = 1'b0;
    @(posedge CLK);
    #1;
    chk("estop_release_ready", int'(ready[0]), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    RST   = 1'b1;
    ESTOP = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid[i] = 1'b0;
      cl[i]    = 5'd16;
      cr[i]    = 5'd16;
    end
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_mc1", int'(mc1[0]), 16);
    chk("rst_mc2", int'(mc2[0]), 16);
    chk("rst_at_target", int'(at[0]), 1);
    chk("rst_wdog_trip", int'(wd[0]), 0);
    chk("rst_tick", int'(tick[0]), 0);
    chk("rst_ready", int'(ready[0]), 0);
    @(negedge CLK);
    RST = 1'b0;

    // Basic ramp in both directions.
    wait_tick(0);
    cmd(0, 1, 20, 12);
    push(0, 17, 15, 0, 0); push(0, 18, 14, 0, 0); push(0, 19, 13, 0, 0); push(0, 20, 12, 1, 0);
    drain(0);

    // Reversal with a two-tick dwell at neutral.
    cmd(0, 1, 13, 12);
    push(0, 19, 12, 0, 0); push(0, 18, 12, 0, 0); push(0, 17, 12, 0, 0);
    push(0, 16, 12, 0, 0); push(0, 16, 12, 0, 0); push(0, 16, 12, 0, 0);
    push(0, 15, 12, 0, 0); push(0, 14, 12, 0, 0); push(0, 13, 12, 1, 0);
    drain(0);

    estop_pulse(1);

    // Mid-ramp retarget on the same side: no dwell.
    wait_tick(0);
    cmd(0, 1, 24, 8);
    push(0, 17, 15, 0, 0); push(0, 18, 14, 0, 0);
    drain(0);
    cmd(0, 1, 17, 8);
    push(0, 17, 13, 0, 0); push(0, 17, 12, 0, 0); push(0, 17, 11, 0, 0);
    push(0, 17, 10, 0, 0); push(0, 17, 9, 0, 0);  push(0, 17, 8, 1, 0);
    drain(0);

    // Emergency stop from 24/8, then resume.
    cmd(0, 1, 24, 8);
    for (int v = 18; v < 24; v++) push(0, v, 8, 0, 0);
    push(0, 24, 8, 1, 0);
    drain(0);
    estop_pulse(6);
    wait_tick(0);
    cmd(0, 1, 18, 16);
    push(0, 17, 16, 0, 0); push(0, 18, 16, 1, 0);
    drain(0);

    // Large step: clamps at 31 and 0, exact landing on neutral, dwell.
    wait_tick(1);
    cmd(1, 1, 31, 16);
    push(1, 21, 16, 0, 0); push(1, 26, 16, 0, 0); push(1, 31, 16, 1, 0);
    drain(1);
    cmd(1, 1, 0, 16);
    push(1, 26, 16, 0, 0); push(1, 21, 16, 0, 0); push(1, 16, 16, 0, 0);
    push(1, 16, 16, 0, 0); push(1, 16, 16, 0, 0); push(1, 11, 16, 0, 0);
    push(1, 6, 16, 0, 0);  push(1, 1, 16, 0, 0);  push(1, 0, 16, 1, 0);
    drain(1);

    // Watchdog: fires on the 8th tick after the last accept.
    wait_tick(2);
    cmd(2, 1, 20, 16);
    push(2, 17, 16, 0, 0); push(2, 18, 16, 0, 0); push(2, 19, 16, 0, 0); push(2, 20, 16, 1, 0);
    push(2, 20, 16, 1, 0); push(2, 20, 16, 1, 0); push(2, 20, 16, 1, 0);
`ifdef MC_CMD_WATCHDOG_EN
    push(2, 19, 16, 0, 1); push(2, 18, 16, 0, 1); push(2, 17, 16, 0, 1); push(2, 16, 16, 1, 1);
`else
    push(2, 20, 16, 1, 0); push(2, 20, 16, 1, 0); push(2, 20, 16, 1, 0); push(2, 20, 16, 1, 0);
`endif
    drain(2);

    // Accept landing on the would-be firing tick keeps the block running.
    cmd(2, 1, 20, 16);
`ifdef MC_CMD_WATCHDOG_EN
    push(2, 17, 16, 0, 0); push(2, 18, 16, 0, 0); push(2, 19, 16, 0, 0);
`else
    push(2, 20, 16, 1, 0); push(2, 20, 16, 1, 0); push(2, 20, 16, 1, 0);
`endif
    push(2, 20, 16, 1, 0); push(2, 20, 16, 1, 0); push(2, 20, 16, 1, 0); push(2, 20, 16, 1, 0);
    drain(2);
    cmd(2, 3, 20, 16);
    push(2, 20, 16, 1, 0); push(2, 20, 16, 1, 0); push(2, 20, 16, 1, 0);
    drain(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
